mem_dreq_ctrl: RTL and testbench
================================

Name: mem_dreq_ctrl

Overview:
Sequences one SRAM-like data-bus transaction per MEM-stage load/store: issues the request, holds it until address handshake, waits for data return, buffers the read word and reports completion to the MEM stage. The buffered word and its byte offset feed the MEM-stage load-extract/merge logic. Handles pipeline flush with a transaction in flight by draining the orphaned response. At most one transaction is outstanding.

Parameters:
DATA_W, 32, data/address width (only 32 supported)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
op_req  in  1  MEM stage has a memory op; level, held until op_done&op_ack or op_flush
op_wr  in  1  1=store, 0=load
op_size  in  2  0=byte, 1=half, 2=word
op_addr  in  32  byte address
op_wstrb  in  4  store byte enables
op_wdata  in  32  store data, pre-aligned
op_flush  in  1  pulse; cancels the current op (exception/eret)
op_ack  in  1  MEM stage consumes result
op_done  out  1  transaction complete, op_rdata valid
op_rdata  out  32  returned word (loads); 0 for stores
op_ea  out  2  latched op_addr[1:0] for load extraction
op_busy  out  1  controller not IDLE (stall MEM stage)
data_req  out  1  bus request
data_wr  out  1  bus write
data_size  out  2  bus size
data_addr  out  32  bus address
data_wstrb  out  4  bus byte enables
data_wdata  out  32  bus write data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  response returned
data_rdata  in  32  read data

Behaviour:
- Reset (resetn=0, async): state=IDLE; cancel flag=0; all outputs 0; latched fields 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: op_req & ~op_flush -> latch wr/size/addr/wstrb/wdata, go REQ. op_req & op_flush same cycle -> stay IDLE, nothing latched.
- REQ: data_req=1, bus fields driven only from latched registers; held stable until data_addr_ok. On addr_ok -> WAIT. data_data_ok in REQ is ignored (nothing outstanding). op_flush in REQ sets cancel flag; the request is not withdrawn.
- WAIT: data_req=0. op_flush sets cancel flag. On data_data_ok: cancel flag set -> IDLE, clear flag, no op_done. Otherwise capture data_rdata (loads; 0 for stores) into rbuf -> DONE.
- DONE: op_done=1, op_rdata=rbuf; hold until op_ack or op_flush -> IDLE. New op accepted the cycle after, never the same cycle.
- op_flush with op_ack in DONE -> IDLE, same as ack.
- A flush arriving in the same cycle as addr_ok or data_ok is recorded: the response is drained, never reported.
- op_busy=1 in REQ, WAIT, DONE. op_ea=latched addr[1:0], stable from REQ through DONE.
- Latency with zero bus wait: op_req at cycle 0; data_req at 1; addr_ok at 1; data_ok at 2; op_done at 3.
- Protocol: controller never raises data_req while a response is owed. Bus field changes while data_req=1 & ~addr_ok are a bug (assertion in bench).

Optional Feature:
RDATA_BYPASS_EN
- Defined: in WAIT, a non-cancelled data_data_ok raises op_done combinationally in that cycle, with op_rdata=data_rdata. op_ack the same cycle -> IDLE. Otherwise -> DONE holding rbuf. This saves one cycle.
- Undefined: op_done only from DONE (registered), as above.

Test Plan:
- Word load at 0x1000, addr_ok at cycle 1, data_ok with 0xDEADBEEF at cycle 2 -> data_req=1 only in cycle 1; op_done at cycle 3 with op_rdata=0xDEADBEEF; op_ea=0.
- Store to 0x2003, size 0, wstrb 4'b1000, wdata 0x11000000, addr_ok delayed 3 cycles -> data_req and all bus fields stable for 4 cycles; op_done after data_ok; op_rdata=0.
- op_flush in WAIT, then data_ok with 0x12345678 -> no op_done, state IDLE; next load returns its own data, not 0x12345678.
- op_flush during REQ before addr_ok -> data_req held until addr_ok; response drained; op_done never set.
- op_req & op_flush in same IDLE cycle -> data_req stays 0; op_busy stays 0.
- resetn low while in WAIT -> all outputs 0 immediately; after release, a fresh load completes normally. With RDATA_BYPASS_EN, op_done coincides with data_ok.

Source files
------------

// File: rtl/mem_dreq_ctrl.sv
// mem_dreq_ctrl: one-outstanding SRAM-like data-bus sequencer for the MEM stage.
// Optional macro RDATA_BYPASS_EN reports the returned word in the data_ok cycle.
module mem_dreq_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              op_req,
  input  logic              op_wr,
  input  logic [1:0]        op_size,
  input  logic [DATA_W-1:0] op_addr,
  input  logic [3:0]        op_wstrb,
  input  logic [DATA_W-1:0] op_wdata,
  input  logic              op_flush,
  input  logic              op_ack,
  output logic              op_done,
  output logic [DATA_W-1:0] op_rdata,
  output logic [1:0]        op_ea,
  output logic              op_busy,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [DATA_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic              cancel_q, cancel_d;
  logic              latch_en;
  logic              kill;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] addr_q;
  logic [3:0]        wstrb_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;

  // Next-state, cancel tracking, read capture and MEM-stage reporting.
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    rbuf_d   = rbuf_q;
    latch_en = 1'b0;
    op_done  = 1'b0;
    op_rdata = '0;
    kill     = cancel_q | op_flush;
    unique case (state_q)
      S_IDLE: begin
        if (op_req && !op_flush) begin
          latch_en = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        cancel_d = kill;
        if (data_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cancel_d = kill;
        if (data_data_ok) begin
          if (kill) begin
            state_d  = S_IDLE;
            cancel_d = 1'b0;
          end else begin
            rbuf_d  = wr_q ? '0 : data_rdata;
            state_d = S_DONE;
`ifdef RDATA_BYPASS_EN
            op_done  = 1'b1;
            op_rdata = rbuf_d;
            if (op_ack) begin
              state_d = S_IDLE;
            end
`endif
          end
        end
      end
      S_DONE: begin
        op_done  = 1'b1;
        op_rdata = rbuf_q;
        if (op_ack || op_flush) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, cancel flag and read buffer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cancel_q <= 1'b0;
      rbuf_q   <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      rbuf_q   <= rbuf_d;
    end
  end

  // Request fields captured once on acceptance; bus is driven only from these.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wstrb_q <= 4'd0;
      wdata_q <= '0;
    end else if (latch_en) begin
      wr_q    <= op_wr;
      size_q  <= op_size;
      addr_q  <= op_addr;
      wstrb_q <= op_wstrb;
      wdata_q <= op_wdata;
    end
  end

  assign op_busy    = (state_q != S_IDLE);
  assign op_ea      = addr_q[1:0];
  assign data_req   = (state_q == S_REQ);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wstrb = wstrb_q;
  assign data_wdata = wdata_q;

endmodule

// File: tb/tb_mem_dreq_ctrl.sv
// tb_mem_dreq_ctrl: table vectors, hand sequences and random ops
// against a memory-backed bus slave and rule-based completion model.
module tb_mem_dreq_ctrl;

`ifdef RDATA_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_req, op_wr, op_flush, op_ack;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata;
  logic [3:0]  op_wstrb;
  logic        op_done, op_busy;
  logic [31:0] op_rdata;
  logic [1:0]  op_ea;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  always #5 clk = ~clk;

  mem_dreq_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .op_req(op_req), .op_wr(op_wr), .op_size(op_size),
    .op_addr(op_addr), .op_wstrb(op_wstrb), .op_wdata(op_wdata),
    .op_flush(op_flush), .op_ack(op_ack),
    .op_done(op_done), .op_rdata(op_rdata), .op_ea(op_ea),
    .op_busy(op_busy),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  typedef struct {
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          adly;
    int          ddly;
    int          fl;
    int          ackd;
    logic [31:0] pre;
    bit          edone;
    int          ecyc;
    logic [31:0] edata;
    int          ereq;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mem [256];
  bit          pend = 1'b0;
  int          pcnt = 0;
  logic [31:0] pdata = '0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  logic        hold_q = 1'b0;
  logic [70:0] bus_q = '0;

  always @(posedge clk) begin
    if (resetn && hold_q)
      chk("bus_stable",
          {data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata},
          {1'b1, bus_q});
    hold_q = resetn && data_req && !data_addr_ok;
    bus_q  = {data_wr, data_size, data_addr, data_wstrb, data_wdata};
  end

  task automatic run_op(input vec_t v, output int ndone, output int dcyc,
                        output logic [31:0] ddata, output logic [1:0] dea,
                        output int nreq, output int nbusy, output int rcyc,
                        output int flat);
    int  reqc, dseen;
    bit  live, fin, owed;
    ndone = 0; dcyc = -1; ddata = '0; dea = '0;
    nreq = 0; nbusy = 0; rcyc = 999; flat = -1;
    reqc = 0; dseen = 0; live = 1'b1; fin = 1'b0;
    op_wr = v.wr; op_size = v.size; op_addr = v.addr;
    op_wstrb = v.wstrb; op_wdata = v.wdata;
    for (int c = 0; c < 60; c++) begin
      op_req = live;
      op_flush = live && (c == v.fl);
      if (op_flush) flat = c;
      op_ack = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata = $urandom;
      owed = pend;
      if (pend) begin
        if (pcnt == 0) begin
          data_data_ok = 1'b1;
          data_rdata = pdata;
          pend = 1'b0;
          rcyc = c;
        end else begin
          pcnt--;
        end
      end
      if (data_req) begin
        nreq++;
        chk("req_while_owed", {127'd0, owed}, 128'd0);
        if (reqc == v.adly) begin
          data_addr_ok = 1'b1;
          pend = 1'b1;
          pcnt = v.ddly;
          chk("bus_fields",
              {data_wr, data_size, data_addr, data_wstrb, data_wdata},
              {v.wr, v.size, v.addr, v.wstrb, v.wdata});
          if (data_wr) begin
            pdata = $urandom;
            for (int b = 0; b < 4; b++)
              if (data_wstrb[b])
                mem[data_addr[9:2]][8*b +: 8] = data_wdata[8*b +: 8];
          end else begin
            pdata = mem[data_addr[9:2]];
          end
        end
        reqc++;
      end
      @(negedge clk);
      if (op_busy) nbusy++;
      if (op_done) begin
        if (dseen == 0) begin
          dcyc = c; ddata = op_rdata; dea = op_ea;
        end
        dseen++;
        ndone++;
        if (dseen > v.ackd) op_ack = 1'b1;
      end
      if (op_flush || op_ack) live = 1'b0;
      @(posedge clk); #1;
      op_req = 1'b0; op_flush = 1'b0; op_ack = 1'b0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      if (!live && !pend && !op_busy) begin
        fin = 1'b1;
        break;
      end
    end
    if (!fin) chk("op_timeout", 128'd0, 128'd1);
  endtask

  vec_t tbl[12];

  initial begin
    int nd, dc, nr, nb, rc, fa;
    logic [31:0] dd;
    logic [1:0]  de;
    vec_t r;
    logic [7:0]  id8;
    logic [1:0]  off;
    logic [31:0] expd;
    bit          expdone;
    int          expreq;

    resetn = 1'b0;
    op_req = 0; op_wr = 0; op_size = 0; op_addr = 0; op_wstrb = 0;
    op_wdata = 0; op_flush = 0; op_ack = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    tbl[0]  = '{0, 2'd2, 32'h1000, 4'h0, 32'h0, 0, 0, -1, 0,
                32'hDEADBEEF, 1, 3, 32'hDEADBEEF, 1};
    tbl[1]  = '{1, 2'd0, 32'h2003, 4'b1000, 32'h11000000, 3, 0, -1, 0,
                32'h0, 1, 6, 32'h0, 4};
    tbl[2]  = '{0, 2'd1, 32'h0042, 4'h0, 32'h0, 1, 2, -1, 1,
                32'hCAFEF00D, 1, 6, 32'hCAFEF00D, 2};
    tbl[3]  = '{0, 2'd2, 32'h0100, 4'h0, 32'h0, 0, 3, 3, 0,
                32'h12345678, 0, 0, 32'h0, 1};
    tbl[4]  = '{0, 2'd2, 32'h0104, 4'h0, 32'h0, 0, 0, -1, 0,
                32'h0BADF00D, 1, 3, 32'h0BADF00D, 1};
    tbl[5]  = '{0, 2'd2, 32'h0200, 4'h0, 32'h0, 2, 1, 1, 0,
                32'h55AA55AA, 0, 0, 32'h0, 3};
    tbl[6]  = '{0, 2'd2, 32'h0204, 4'h0, 32'h0, 0, 0, 0, 0,
                32'h01020304, 0, 0, 32'h0, 0};
    tbl[7]  = '{0, 2'd2, 32'h0208, 4'h0, 32'h0, 0, 1, 3, 0,
                32'hA5A5A5A5, 0, 0, 32'h0, 1};
    tbl[8]  = '{0, 2'd2, 32'h020C, 4'h0, 32'h0, 1, 0, 2, 0,
                32'h5A5A5A5A, 0, 0, 32'h0, 2};
    tbl[9]  = '{0, 2'd2, 32'h0210, 4'h0, 32'h0, 0, 0, 4, 2,
                32'h600DCAFE, 1, 3, 32'h600DCAFE, 1};
    tbl[10] = '{0, 2'd2, 32'h0214, 4'h0, 32'h0, 0, 0, 3, 0,
                32'h7777AAAA, 1, 3, 32'h7777AAAA, 1};
    tbl[11] = '{0, 2'd0, 32'h0219, 4'h0, 32'h0, 2, 1, -1, 0,
                32'h89ABCDEF, 1, 6, 32'h89ABCDEF, 3};

    #3;
    chk("reset_outs_a", {op_done, op_rdata, op_ea, op_busy, data_req},
        128'd0);
    chk("reset_outs_b", {data_wr, data_size, data_addr, data_wstrb,
        data_wdata}, 128'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      mem[tbl[i].addr[9:2]] = tbl[i].pre;
      run_op(tbl[i], nd, dc, dd, de, nr, nb, rc, fa);
      chk($sformatf("v%0d_done", i), {127'd0, nd > 0},
          {127'd0, tbl[i].edone});
      chk($sformatf("v%0d_nreq", i), nr, tbl[i].ereq);
      chk($sformatf("v%0d_busy", i), {127'd0, nb > 0},
          {127'd0, tbl[i].ereq > 0});
      if (tbl[i].edone) begin
        chk($sformatf("v%0d_cyc", i), dc, tbl[i].ecyc - BYP);
        chk($sformatf("v%0d_rdata", i), dd, tbl[i].edata);
        chk($sformatf("v%0d_ea", i), de, tbl[i].addr[1:0]);
      end
      if (tbl[i].wr)
        chk($sformatf("v%0d_mem", i), mem[tbl[i].addr[9:2]],
            32'h11000000);
    end

    op_wr = 1'b0; op_size = 2'd2; op_addr = 32'h300;
    op_wstrb = 4'h0; op_wdata = 32'h0;
    op_req = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    chk("wait_state", {op_busy, data_req, op_done}, 3'b100);
    resetn = 1'b0;
    #1;
    chk("rst_wait_a", {op_done, op_rdata, op_ea, op_busy, data_req},
        128'd0);
    chk("rst_wait_b", {data_wr, data_size, data_addr, data_wstrb,
        data_wdata}, 128'd0);
    op_req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    r = '{0, 2'd2, 32'h0304, 4'h0, 32'h0, 0, 0, -1, 0,
          32'h3C3C3C3C, 1, 3, 32'h3C3C3C3C, 1};
    mem[r.addr[9:2]] = r.pre;
    run_op(r, nd, dc, dd, de, nr, nb, rc, fa);
    chk("post_rst_cyc", dc, 3 - BYP);
    chk("post_rst_data", dd, 32'h3C3C3C3C);
    chk("post_rst_nreq", nr, 1);

    for (int i = 0; i < 150; i++) begin
      r.wr = 1'($urandom_range(0, 1));
      r.size = 2'($urandom_range(0, 2));
      id8 = 8'($urandom_range(0, 255));
      off = 2'($urandom_range(0, 3));
      if (r.size == 2'd1) off[0] = 1'b0;
      if (r.size == 2'd2) off = 2'd0;
      r.addr = {22'd0, id8, off};
      r.wstrb = (r.size == 2'd0) ? (4'b0001 << off) :
                (r.size == 2'd1) ? (4'b0011 << off) : 4'hF;
      r.wdata = $urandom;
      r.adly = $urandom_range(0, 3);
      r.ddly = $urandom_range(0, 3);
      r.fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
      r.ackd = $urandom_range(0, 2);
      expd = r.wr ? 32'h0 : mem[id8];
      run_op(r, nd, dc, dd, de, nr, nb, rc, fa);
      expdone = !(fa >= 0 && fa <= rc);
      expreq = (fa == 0) ? 0 : r.adly + 1;
      chk($sformatf("r%0d_done", i), {127'd0, nd > 0}, {127'd0, expdone});
      chk($sformatf("r%0d_nreq", i), nr, expreq);
      chk($sformatf("r%0d_busy", i), {127'd0, nb > 0},
          {127'd0, expreq > 0});
      if (expdone) begin
        chk($sformatf("r%0d_cyc", i), dc, rc + 1 - BYP);
        chk($sformatf("r%0d_rdata", i), dd, expd);
        chk($sformatf("r%0d_ea", i), de, r.addr[1:0]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
